piso_serializer: RTL and testbench

- Parallel-in, serial-out transmitter for the 8-bit flop datapath.
- Accepts one DATA_W-bit word per valid/ready handshake and shifts it out one bit per clock, with a serial-valid qualifier.
- Sits downstream of the data registers and feeds single-wire links or serial test ports.

---
 rtl/piso_pkg.sv | 11 +
 rtl/piso_bit_counter.sv | 30 +++
 rtl/piso_serializer.sv | 81 ++++++++
 tb/tb_piso_serializer.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/piso_pkg.sv
// Shared types and defaults for the parallel-in, serial-out transmitter.
package piso_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } piso_state_e;

   localparam int DEFAULT_DATA_W = 8;

endpackage

// File: rtl/piso_bit_counter.sv
// Loadable down-counter that tracks the remaining bits of the word being sent.
module piso_bit_counter
   import piso_pkg::*;
#(
   parameter int CNT_W = $clog2(DEFAULT_DATA_W)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             dec,
   input  logic [CNT_W-1:0] load_value,
   output logic             zero
);

   logic [CNT_W-1:0] count;

   // A load wins over a decrement so a back-to-back word restarts the count cleanly.
   always_ff @(posedge clk) begin
      if (reset) begin
         count <= '0;
      end else if (load) begin
         count <= load_value;
      end else if (dec) begin
         count <= count - 1'b1;
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/piso_serializer.sv
// Accepts one parallel word per valid/ready handshake and shifts it out a bit per clock.
module piso_serializer
   import piso_pkg::*;
#(
   parameter int DATA_W    = DEFAULT_DATA_W,
   parameter bit LSB_FIRST = 1'b1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] din,
   input  logic              din_valid,
   output logic              din_ready,
   output logic              sout,
   output logic              sout_valid,
   output logic              busy,
   output logic              done
);

   localparam int               CNT_W    = $clog2(DATA_W);
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_W - 1);

   piso_state_e       state;
   piso_state_e       state_next;
   logic [DATA_W-1:0] shreg;
   logic              cnt_zero;
   logic              last_bit;
   logic              xfer;

   assign last_bit  = (state == SHIFT) && cnt_zero;
   assign din_ready = !reset && ((state == IDLE) || last_bit);
   assign xfer      = din_valid && din_ready;

   piso_bit_counter #(
      .CNT_W(CNT_W)
   ) u_bit_counter (
      .clk       (clk),
      .reset     (reset),
      .load      (xfer),
      .dec       ((state == SHIFT) && !cnt_zero),
      .load_value(LAST_IDX),
      .zero      (cnt_zero)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (xfer) state_next = SHIFT;
         SHIFT:   if (last_bit) state_next = xfer ? SHIFT : IDLE;
         default: state_next = IDLE;
      endcase
   end

   // A fresh word overwrites whatever zero-filled remnant is left from the previous one.
   always_ff @(posedge clk) begin
      if (reset) begin
         shreg <= '0;
      end else if (xfer) begin
         shreg <= din;
      end else if (state == SHIFT) begin
         if (LSB_FIRST) begin
            shreg <= {1'b0, shreg[DATA_W-1:1]};
         end else begin
            shreg <= {shreg[DATA_W-2:0], 1'b0};
         end
      end
   end

   assign sout_valid = (state == SHIFT);
   assign busy       = (state == SHIFT);
   assign done       = last_bit;
   assign sout       = sout_valid && (LSB_FIRST ? shreg[0] : shreg[DATA_W-1]);

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: one LSB-first and one MSB-first instance share stimulus.
module tb_piso_serializer;

   logic       clk;
   logic       reset;
   logic [7:0] din;
   logic       din_valid;

   logic lsb_ready, lsb_sout, lsb_valid, lsb_busy, lsb_done;
   logic msb_ready, msb_sout, msb_valid, msb_busy, msb_done;

   int checks = 0;
   int errors = 0;

   piso_serializer #(.DATA_W(8), .LSB_FIRST(1'b1)) dut_lsb (
      .clk       (clk),
      .reset     (reset),
      .din       (din),
      .din_valid (din_valid),
      .din_ready (lsb_ready),
      .sout      (lsb_sout),
      .sout_valid(lsb_valid),
      .busy      (lsb_busy),
      .done      (lsb_done)
   );

   piso_serializer #(.DATA_W(8), .LSB_FIRST(1'b0)) dut_msb (
      .clk       (clk),
      .reset     (reset),
      .din       (din),
      .din_valid (din_valid),
      .din_ready (msb_ready),
      .sout      (msb_sout),
      .sout_valid(msb_valid),
      .busy      (msb_busy),
      .done      (msb_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic test_reset();
      reset     = 1'b1;
      din       = 8'h00;
      din_valid = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++; if (lsb_sout !== 1'b0)  begin errors++; $display("[TB] FAIL reset_sout got %b want 0", lsb_sout); end
      checks++; if (lsb_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_sout_valid got %b want 0", lsb_valid); end
      checks++; if (lsb_busy !== 1'b0)  begin errors++; $display("[TB] FAIL reset_busy got %b want 0", lsb_busy); end
      checks++; if (lsb_done !== 1'b0)  begin errors++; $display("[TB] FAIL reset_done got %b want 0", lsb_done); end
      checks++; if (lsb_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_din_ready got %b want 0", lsb_ready); end
      reset = 1'b0;
      #1;
      checks++; if (lsb_ready !== 1'b1) begin errors++; $display("[TB] FAIL idle_din_ready got %b want 1", lsb_ready); end
   endtask

   task automatic test_lsb_word();
      bit exp_l [8] = '{1, 1, 1, 1, 0, 0, 0, 0};
      bit exp_m [8] = '{0, 0, 0, 0, 1, 1, 1, 1};
      @(negedge clk);
      din = 8'h0F; din_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      din_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         checks++; if (lsb_sout !== exp_l[i]) begin errors++; $display("[TB] FAIL lsb_bit%0d got %b want %b", i, lsb_sout, exp_l[i]); end
         checks++; if (msb_sout !== exp_m[i]) begin errors++; $display("[TB] FAIL msb_bit%0d got %b want %b", i, msb_sout, exp_m[i]); end
         checks++; if (lsb_valid !== 1'b1) begin errors++; $display("[TB] FAIL lsb_valid%0d got %b want 1", i, lsb_valid); end
         checks++; if (lsb_done !== (i == 7)) begin errors++; $display("[TB] FAIL lsb_done%0d got %b want %b", i, lsb_done, (i == 7)); end
         checks++; if (lsb_ready !== (i == 7)) begin errors++; $display("[TB] FAIL lsb_ready%0d got %b want %b", i, lsb_ready, (i == 7)); end
         @(negedge clk);
      end
      checks++; if (lsb_valid !== 1'b0) begin errors++; $display("[TB] FAIL lsb_after_valid got %b want 0", lsb_valid); end
      checks++; if (lsb_sout !== 1'b0)  begin errors++; $display("[TB] FAIL lsb_after_sout got %b want 0", lsb_sout); end
   endtask

   task automatic test_msb_word();
      bit exp_m [8] = '{1, 1, 1, 1, 1, 1, 1, 0};
      @(negedge clk);
      din = 8'hFE; din_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      din_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         checks++; if (msb_sout !== exp_m[i]) begin errors++; $display("[TB] FAIL msbw_bit%0d got %b want %b", i, msb_sout, exp_m[i]); end
         checks++; if (msb_done !== (i == 7)) begin errors++; $display("[TB] FAIL msbw_done%0d got %b want %b", i, msb_done, (i == 7)); end
         @(negedge clk);
      end
      checks++; if (msb_valid !== 1'b0) begin errors++; $display("[TB] FAIL msbw_after_valid got %b want 0", msb_valid); end
      checks++; if (msb_ready !== 1'b1) begin errors++; $display("[TB] FAIL msbw_after_ready got %b want 1", msb_ready); end
   endtask

   task automatic test_back_to_back();
      bit exp_l [16] = '{1, 1, 1, 1, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1};
      @(negedge clk);
      din = 8'h0F; din_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      din = 8'hFE;
      for (int i = 0; i < 16; i++) begin
         if (i == 8) din_valid = 1'b0;
         checks++; if (lsb_sout !== exp_l[i]) begin errors++; $display("[TB] FAIL b2b_bit%0d got %b want %b", i, lsb_sout, exp_l[i]); end
         checks++; if (lsb_valid !== 1'b1) begin errors++; $display("[TB] FAIL b2b_valid%0d got %b want 1", i, lsb_valid); end
         checks++; if (lsb_done !== (i == 7 || i == 15)) begin errors++; $display("[TB] FAIL b2b_done%0d got %b want %b", i, lsb_done, (i == 7 || i == 15)); end
         @(negedge clk);
      end
      checks++; if (lsb_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_after_valid got %b want 0", lsb_valid); end
   endtask

   task automatic test_ignore_while_busy();
      bit exp_l [8] = '{1, 1, 1, 1, 0, 0, 0, 0};
      @(negedge clk);
      din = 8'h0F; din_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      din_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (i == 2) begin din = 8'hAA; din_valid = 1'b1; end
         if (i == 5) din_valid = 1'b0;
         checks++; if (lsb_sout !== exp_l[i]) begin errors++; $display("[TB] FAIL ign_bit%0d got %b want %b", i, lsb_sout, exp_l[i]); end
         @(negedge clk);
      end
      checks++; if (lsb_valid !== 1'b0) begin errors++; $display("[TB] FAIL ign_after_valid got %b want 0", lsb_valid); end
      checks++; if (lsb_busy !== 1'b0)  begin errors++; $display("[TB] FAIL ign_after_busy got %b want 0", lsb_busy); end
   endtask

   task automatic test_reset_mid_word();
      bit exp_first [3] = '{0, 1, 1};
      bit exp_l     [8] = '{1, 1, 1, 1, 0, 0, 0, 0};
      @(negedge clk);
      din = 8'hFE; din_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      din_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if (i > 0) @(negedge clk);
         checks++; if (lsb_sout !== exp_first[i]) begin errors++; $display("[TB] FAIL rmid_bit%0d got %b want %b", i, lsb_sout, exp_first[i]); end
      end
      reset = 1'b1;
      #1;
      checks++; if (lsb_valid !== 1'b1) begin errors++; $display("[TB] FAIL rmid_hold_valid got %b want 1", lsb_valid); end
      checks++; if (lsb_busy !== 1'b1)  begin errors++; $display("[TB] FAIL rmid_hold_busy got %b want 1", lsb_busy); end
      checks++; if (lsb_sout !== 1'b1)  begin errors++; $display("[TB] FAIL rmid_hold_sout got %b want 1", lsb_sout); end
      checks++; if (lsb_ready !== 1'b0) begin errors++; $display("[TB] FAIL rmid_hold_ready got %b want 0", lsb_ready); end
      @(posedge clk);
      #1;
      checks++; if (lsb_valid !== 1'b0) begin errors++; $display("[TB] FAIL rmid_rst_valid got %b want 0", lsb_valid); end
      checks++; if (lsb_busy !== 1'b0)  begin errors++; $display("[TB] FAIL rmid_rst_busy got %b want 0", lsb_busy); end
      checks++; if (lsb_sout !== 1'b0)  begin errors++; $display("[TB] FAIL rmid_rst_sout got %b want 0", lsb_sout); end
      checks++; if (lsb_done !== 1'b0)  begin errors++; $display("[TB] FAIL rmid_rst_done got %b want 0", lsb_done); end
      @(negedge clk);
      reset = 1'b0;
      din = 8'h0F; din_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      din_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         checks++; if (lsb_sout !== exp_l[i]) begin errors++; $display("[TB] FAIL rmid_new_bit%0d got %b want %b", i, lsb_sout, exp_l[i]); end
         checks++; if (lsb_done !== (i == 7)) begin errors++; $display("[TB] FAIL rmid_new_done%0d got %b want %b", i, lsb_done, (i == 7)); end
         @(negedge clk);
      end
   endtask

   task automatic test_reset_blocks_transfer();
      bit exp_l [8] = '{1, 1, 1, 1, 0, 0, 0, 0};
      @(negedge clk);
      reset = 1'b1;
      din = 8'h0F; din_valid = 1'b1;
      #1;
      checks++; if (lsb_ready !== 1'b0) begin errors++; $display("[TB] FAIL rblk_ready got %b want 0", lsb_ready); end
      @(posedge clk);
      @(negedge clk);
      checks++; if (lsb_valid !== 1'b0) begin errors++; $display("[TB] FAIL rblk_valid1 got %b want 0", lsb_valid); end
      @(negedge clk);
      checks++; if (lsb_busy !== 1'b0)  begin errors++; $display("[TB] FAIL rblk_busy2 got %b want 0", lsb_busy); end
      reset = 1'b0;
      #1;
      checks++; if (lsb_ready !== 1'b1) begin errors++; $display("[TB] FAIL rblk_ready_after got %b want 1", lsb_ready); end
      @(posedge clk);
      @(negedge clk);
      din_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         checks++; if (lsb_sout !== exp_l[i]) begin errors++; $display("[TB] FAIL rblk_bit%0d got %b want %b", i, lsb_sout, exp_l[i]); end
         @(negedge clk);
      end
      checks++; if (lsb_valid !== 1'b0) begin errors++; $display("[TB] FAIL rblk_end_valid got %b want 0", lsb_valid); end
   endtask

   initial begin
      test_reset();
      test_lsb_word();
      test_msb_word();
      test_back_to_back();
      test_ignore_while_busy();
      test_reset_mid_word();
      test_reset_blocks_transfer();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
